// File: rtl/vga_draw_sched_if.sv
// Bundled control, engine and VGA write-port signals of the drawing scheduler.
// The slave modport is the scheduler; the master modport is the top level driving it.
interface vga_draw_sched_if #(
  parameter int NUM_REQ = 4
);
  // Handshakes: start is a level request answered by done, and done holds until start drops.
  // req_start[i] stays high until the engine raises req_done[i].
  // req_done[i] must then fall before the next job can be scanned.
  logic                   start;
  logic [NUM_REQ-1:0]     job_en;
  logic                   done;
  logic [NUM_REQ-1:0]     req_start;
  logic [NUM_REQ-1:0]     req_done;
  logic [NUM_REQ*8-1:0]   req_x;
  logic [NUM_REQ*7-1:0]   req_y;
  logic [NUM_REQ*3-1:0]   req_colour;
  logic [NUM_REQ-1:0]     req_plot;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [2:0]             vga_colour;
  logic                   vga_plot;
  logic [2:0]             active_job;
  logic [15:0]            plot_count;
  logic [2:0]             state_dbg;

  modport master (
    output start, job_en, req_done, req_x, req_y, req_colour, req_plot,
    input  done, req_start, vga_x, vga_y, vga_colour, vga_plot,
           active_job, plot_count, state_dbg
  );

  modport slave (
    input  start, job_en, req_done, req_x, req_y, req_colour, req_plot,
    output done, req_start, vga_x, vga_y, vga_colour, vga_plot,
           active_job, plot_count, state_dbg
  );
endinterface

// File: rtl/vga_draw_sched.sv
// Runs the enabled drawing engines one after another and muxes the active engine onto the VGA port.
// Define VGA_DRAW_SCHED_CLIP_EN to drop pixels outside the 160x120 screen.
module vga_draw_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  vga_draw_sched_if.slave  bus
);
  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]          state;
  logic [IW-1:0]       idx;
  logic [NUM_REQ-1:0]  job_en_q;
  logic                done_q;
  logic [7:0]          vga_x_q;
  logic [6:0]          vga_y_q;
  logic [2:0]          vga_colour_q;
  logic                vga_plot_q;
  logic [15:0]         plot_count_q;

  logic                cur_en;
  logic                cur_done;
  logic                cur_plot;
  logic [7:0]          sel_x;
  logic [6:0]          sel_y;
  logic [2:0]          sel_colour;
  logic [NUM_REQ-1:0]  req_start_c;
  logic                launched;
  logic                last_idx;
  logic                on_screen;
  logic                fwd;

  assign launched = (state == S_LAUNCH) || (state == S_WAIT);
  assign last_idx = (idx == IW'(NUM_REQ - 1));

  // Everything from non-active engines is masked here, so stray done/plot strobes never leak.
  always_comb begin
    cur_en      = 1'b0;
    cur_done    = 1'b0;
    cur_plot    = 1'b0;
    sel_x       = 8'd0;
    sel_y       = 7'd0;
    sel_colour  = 3'd0;
    req_start_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IW'(i)) begin
        cur_en         = job_en_q[i];
        cur_done       = bus.req_done[i];
        cur_plot       = bus.req_plot[i];
        sel_x          = bus.req_x[i*8 +: 8];
        sel_y          = bus.req_y[i*7 +: 7];
        sel_colour     = bus.req_colour[i*3 +: 3];
        req_start_c[i] = launched;
      end
    end
  end

`ifdef VGA_DRAW_SCHED_CLIP_EN
  assign on_screen = (sel_x < 8'd160) && (sel_y < 7'd120);
`else
  assign on_screen = 1'b1;
`endif

  assign fwd = launched && cur_plot && on_screen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      job_en_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_FINISH);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            job_en_q <= bus.job_en;
            idx      <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (cur_en)        state <= S_LAUNCH;
          else if (last_idx) state <= S_FINISH;
          else               idx   <= idx + 1'b1;
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (cur_done) state <= S_RELEASE;
        end
        // The engine must drop done before the next job, so a held done is never mistaken for completion.
        S_RELEASE: begin
          if (!cur_done) begin
            if (last_idx) begin
              state <= S_FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SCAN;
            end
          end
        end
        S_FINISH: begin
          if (!bus.start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      plot_count_q <= 16'd0;
    end else begin
      vga_plot_q <= fwd;
      if (launched && cur_plot) begin
        vga_x_q      <= sel_x;
        vga_y_q      <= sel_y;
        vga_colour_q <= sel_colour;
      end
      if (state == S_IDLE && bus.start)
        plot_count_q <= 16'd0;
      else if (fwd && plot_count_q != 16'hFFFF)
        plot_count_q <= plot_count_q + 16'd1;
    end
  end

  assign bus.done       = done_q;
  assign bus.req_start  = req_start_c;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.plot_count = plot_count_q;
  assign bus.state_dbg  = state;
  assign bus.active_job = (launched || state == S_RELEASE) ? 3'(idx) : 3'd0;
endmodule

// File: tb/tb_vga_draw_sched.sv
// Bench for vga_draw_sched: table of job-mask runs plus hand-written corner sequences.
module tb_vga_draw_sched;
  localparam int N = 4;

  logic clk;
  logic rst;
  vga_draw_sched_if #(.NUM_REQ(N)) bus ();

  vga_draw_sched #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [N-1:0] seen_starts = '0;
  logic [17:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every vga_plot pulse must match the next queued pixel.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("req_start_onehot", ($countones(bus.req_start) <= 1), 1);
        seen_starts = seen_starts | bus.req_start;
        if (bus.vga_plot === 1'b1) begin
          pulses++;
          if (exp_q.size() == 0) begin
            check("unexpected_plot", {bus.vga_x, bus.vga_y, bus.vga_colour}, 18'h3FFFF);
          end else begin
            e = exp_q.pop_front();
            check("pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pix(input int j, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.req_x[j*8 +: 8]      = x;
    bus.req_y[j*7 +: 7]      = y;
    bus.req_colour[j*3 +: 3] = c;
    bus.req_plot[j]          = 1'b1;
  endtask

  task automatic wait_launch();
    int t = 0;
    while (bus.req_start == '0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("launch_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (bus.done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", bus.done, 1);
  endtask

  task automatic begin_seq(input logic [N-1:0] mask);
    seen_starts = '0;
    pulses      = 0;
    bus.job_en  = mask;
    bus.start   = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_seq();
    check("done_held", bus.done, 1);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_one_edge_late", bus.done, 1);
    @(negedge clk);
    check("done_fall", bus.done, 0);
  endtask

  // Engine model: plot npix random on-screen pixels, then hold done for two cycles.
  task automatic serve_job(input int j, input int npix);
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [N-1:0] oh;
    wait_launch();
    oh = '0;
    oh[j] = 1'b1;
    check("launch_order", bus.req_start, oh);
    check("active_job", bus.active_job, j);
    for (int p = 0; p < npix; p++) begin
      x = 8'($urandom_range(0, 159));
      y = 7'($urandom_range(0, 119));
      c = 3'($urandom_range(0, 7));
      set_pix(j, x, y, c);
      exp_q.push_back({x, y, c});
      @(negedge clk);
      bus.req_plot = '0;
    end
    bus.req_done[j] = 1'b1;
    @(negedge clk);
    check("start_drop_on_done", bus.req_start, 0);
    @(negedge clk);
    bus.req_done[j] = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] job_en;
    int           npix;
    logic [N-1:0] exp_starts;
    int           exp_count;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [N-1:0] zero_starts;
    int exp_clip;

    vecs[0] = '{job_en: 4'b1111, npix: 3, exp_starts: 4'b1111, exp_count: 12};
    vecs[1] = '{job_en: 4'b1010, npix: 2, exp_starts: 4'b1010, exp_count: 4};
    vecs[2] = '{job_en: 4'b0000, npix: 0, exp_starts: 4'b0000, exp_count: 0};
    vecs[3] = '{job_en: 4'b0110, npix: 1, exp_starts: 4'b0110, exp_count: 2};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.job_en     = '0;
    bus.req_done   = '0;
    bus.req_plot   = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_state", bus.state_dbg, 0);
    check("rst_done", bus.done, 0);
    check("rst_req_start", bus.req_start, 0);
    check("rst_vga_plot", bus.vga_plot, 0);
    check("rst_plot_count", bus.plot_count, 0);
    check("rst_active_job", bus.active_job, 0);
    @(negedge clk);

    // Table of full sequences
    foreach (vecs[v]) begin
      begin_seq(vecs[v].job_en);
      for (int j = 0; j < N; j++)
        if (vecs[v].job_en[j]) serve_job(j, vecs[v].npix);
      wait_done();
      check("seq_starts", seen_starts, vecs[v].exp_starts);
      check("seq_pulses", pulses, vecs[v].exp_count);
      check("seq_plot_count", bus.plot_count, vecs[v].exp_count);
      end_seq();
      @(negedge clk);
    end

    // Foreign engine strobes ignored; active pixel latency; plot alongside done
    begin_seq(4'b0001);
    wait_launch();
    set_pix(2, 8'd50, 7'd60, 3'd2);
    bus.req_done[2] = 1'b1;
    @(negedge clk);
    check("foreign_plot_blocked", bus.vga_plot, 0);
    check("foreign_done_ignored", bus.req_start, 4'b0001);
    bus.req_plot = '0;
    bus.req_done = '0;
    set_pix(0, 8'd10, 7'd20, 3'b111);
    exp_q.push_back({8'd10, 7'd20, 3'b111});
    @(negedge clk);
    check("lat_plot", bus.vga_plot, 1);
    check("lat_x", bus.vga_x, 10);
    check("lat_y", bus.vga_y, 20);
    check("lat_colour", bus.vga_colour, 3'b111);
    bus.req_plot = '0;
    set_pix(0, 8'd1, 7'd2, 3'd5);
    exp_q.push_back({8'd1, 7'd2, 3'd5});
    bus.req_done[0] = 1'b1;
    @(negedge clk);
    check("plot_with_done", bus.vga_plot, 1);
    check("start_low_after_done", bus.req_start, 0);
    bus.req_plot = '0;
    @(negedge clk);
    bus.req_done = '0;
    wait_done();
    check("iso_plot_count", bus.plot_count, 2);
    end_seq();
    @(negedge clk);

    // Off-screen pixels
`ifdef VGA_DRAW_SCHED_CLIP_EN
    exp_clip = 1;
`else
    exp_clip = 3;
`endif
    begin_seq(4'b0001);
    wait_launch();
    set_pix(0, 8'd159, 7'd119, 3'd1);
    exp_q.push_back({8'd159, 7'd119, 3'd1});
    @(negedge clk);
    set_pix(0, 8'd160, 7'd5, 3'd2);
    if (exp_clip == 3) exp_q.push_back({8'd160, 7'd5, 3'd2});
    @(negedge clk);
    set_pix(0, 8'd5, 7'd120, 3'd3);
    if (exp_clip == 3) exp_q.push_back({8'd5, 7'd120, 3'd3});
    @(negedge clk);
    bus.req_plot = '0;
    bus.req_done[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_done = '0;
    wait_done();
    check("clip_pulses", pulses, exp_clip);
    check("clip_plot_count", bus.plot_count, exp_clip);
    end_seq();
    @(negedge clk);

    // Empty mask: done appears on the sixth edge after start is sampled
    zero_starts = '0;
    begin_seq(4'b0000);
    repeat (4) @(negedge clk);
    check("empty_done_not_yet", bus.done, 0);
    @(negedge clk);
    check("empty_done_timing", bus.done, 1);
    check("empty_no_starts", seen_starts, zero_starts);
    end_seq();
    @(negedge clk);

    // Reset held two cycles in the middle of job 1
    begin_seq(4'b1111);
    serve_job(0, 1);
    wait_launch();
    check("mid_job1", bus.req_start, 4'b0010);
    @(negedge clk);
    check("mid_wait_state", bus.state_dbg, 3);
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mrst_req_start", bus.req_start, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_vga_plot", bus.vga_plot, 0);
    check("mrst_plot_count", bus.plot_count, 0);
    check("mrst_state", bus.state_dbg, 0);
    check("mrst_active_job", bus.active_job, 0);
    @(negedge clk);
    check("mrst_stays_idle", bus.state_dbg, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
